// File: rtl/avalon_packetizer_if.sv
// Avalon-ST streaming bus: one beat of data with framing markers and a ready back-channel.
interface avalon_st_if #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16
);
    localparam int unsigned EMPTY_WIDTH = $clog2(DATA_WIDTH_IN_BYTES);

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_WIDTH-1:0]           empty;
    logic                             rdy;

    modport master (output data, output valid, output sop, output eop, output empty, input rdy);
    modport slave  (input data, input valid, input sop, input eop, input empty, output rdy);
endinterface

// File: rtl/avalon_packetizer.sv
// Transmit-side Avalon-ST framer: turns a byte-length command plus a raw word stream
// into sop/eop/empty-delimited packets through a 1-deep output register.
module avalon_packetizer #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned LEN_WIDTH           = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             len_valid,
    input  logic [LEN_WIDTH-1:0]             len,
    output logic                             len_rdy,
    input  logic                             word_valid,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0] word_data,
    output logic                             word_rdy,
    avalon_st_if.master                      packet_out,
    output logic                             zero_len_drop,
    output logic                             busy
);
    localparam int unsigned B  = DATA_WIDTH_IN_BYTES;
    localparam int unsigned DW = B * 8;
    localparam int unsigned EW = $clog2(B);
    localparam int unsigned CW = LEN_WIDTH + 1;

    typedef enum logic {
        WAIT_FOR_LEN,
        SEND_PACKET
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beats_left, beats_left_nxt;
    logic [EW-1:0]   last_empty, last_empty_nxt;
    logic            first_beat, first_beat_nxt;
    logic            zero_len_drop_nxt;

    logic [DW-1:0]   out_data, out_data_nxt;
    logic            out_valid, out_valid_nxt;
    logic            out_sop, out_sop_nxt;
    logic            out_eop, out_eop_nxt;
    logic [EW-1:0]   out_empty, out_empty_nxt;

    logic            len_fire;
    logic            word_fire;
    logic            last_word;

    // Next-state, handshakes and output-register load/drain.
    always_comb begin
        state_nxt         = state;
        beats_left_nxt    = beats_left;
        last_empty_nxt    = last_empty;
        first_beat_nxt    = first_beat;
        zero_len_drop_nxt = 1'b0;
        out_data_nxt      = out_data;
        out_valid_nxt     = out_valid;
        out_sop_nxt       = out_sop;
        out_eop_nxt       = out_eop;
        out_empty_nxt     = out_empty;

        len_rdy   = rst && (state == WAIT_FOR_LEN);
        word_rdy  = rst && (state == SEND_PACKET) && (!out_valid || packet_out.rdy);
        len_fire  = len_valid && len_rdy;
        word_fire = word_valid && word_rdy;
        last_word = (beats_left == CW'(1));

        // A beat leaving with no replacement empties the register and zeroes its fields.
        if (out_valid && packet_out.rdy) begin
            out_data_nxt  = '0;
            out_valid_nxt = 1'b0;
            out_sop_nxt   = 1'b0;
            out_eop_nxt   = 1'b0;
            out_empty_nxt = '0;
        end

        case (state)
            WAIT_FOR_LEN: begin
                if (len_fire) begin
                    if (len == '0) begin
                        zero_len_drop_nxt = 1'b1;
                    end else begin
                        // Wide sum so len near max does not wrap the beat count.
                        beats_left_nxt = (CW'(len) + CW'(B - 1)) >> EW;
                        last_empty_nxt = EW'(0) - len[EW-1:0];
                        first_beat_nxt = 1'b1;
                        state_nxt      = SEND_PACKET;
                    end
                end
            end
            SEND_PACKET: begin
                if (word_fire) begin
                    out_data_nxt   = word_data;
                    out_valid_nxt  = 1'b1;
                    out_sop_nxt    = first_beat;
                    out_eop_nxt    = last_word;
                    out_empty_nxt  = last_word ? last_empty : '0;
                    first_beat_nxt = 1'b0;
                    beats_left_nxt = beats_left - CW'(1);
                    if (last_word) begin
                        state_nxt = WAIT_FOR_LEN;
                    end
                end
            end
            default: state_nxt = WAIT_FOR_LEN;
        endcase
    end

    // State and datapath registers; async reset truncates any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= WAIT_FOR_LEN;
            beats_left    <= '0;
            last_empty    <= '0;
            first_beat    <= 1'b0;
            zero_len_drop <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            out_empty     <= '0;
        end else begin
            state         <= state_nxt;
            beats_left    <= beats_left_nxt;
            last_empty    <= last_empty_nxt;
            first_beat    <= first_beat_nxt;
            zero_len_drop <= zero_len_drop_nxt;
            out_data      <= out_data_nxt;
            out_valid     <= out_valid_nxt;
            out_sop       <= out_sop_nxt;
            out_eop       <= out_eop_nxt;
            out_empty     <= out_empty_nxt;
        end
    end

    assign packet_out.data  = out_data;
    assign packet_out.valid = out_valid;
    assign packet_out.sop   = out_sop;
    assign packet_out.eop   = out_eop;
    assign packet_out.empty = out_empty;

    assign busy = (state == SEND_PACKET) || out_valid;
endmodule

// File: tb/tb_avalon_packetizer.sv
// Randomized bench for avalon_packetizer with a packet-level scoreboard.
module tb_avalon_packetizer;
    localparam int unsigned B  = 16;
    localparam int unsigned LW = 16;
    localparam int unsigned EW = 4;
    localparam int unsigned DW = 128;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          len_valid;
    logic [LW-1:0] len;
    logic          len_rdy;
    logic          word_valid;
    logic [DW-1:0] word_data;
    logic          word_rdy;
    logic          zero_len_drop;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cmd_q[$];

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(B)) pkt_if ();

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES(B),
        .LEN_WIDTH(LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .len_valid     (len_valid),
        .len           (len),
        .len_rdy       (len_rdy),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_rdy      (word_rdy),
        .packet_out    (pkt_if),
        .zero_len_drop (zero_len_drop),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives commands from cmd_q and a free-running word source; checks every cycle.
    task automatic run_traffic(input bit full, input int budget);
        beat_t         exp_q[$];
        beat_t         exp_b;
        beat_t         prev;
        int            rem = 0, k = 0, n_cur = 0, l_cur = 0, cyc = 0;
        bit            len_fired = 0, word_fired = 0, drop_exp = 0, fired_prev = 0, hold_prev = 0;
        logic          o_valid, o_sop, o_eop, o_rdy;
        logic [EW-1:0] o_empty;
        logic [DW-1:0] o_data;
        prev = '{data: '0, sop: 1'b0, eop: 1'b0, empty: '0};
        do begin
            @(negedge clk);
            if (len_fired) begin
                void'(cmd_q.pop_front());
                len_valid = 1'b0;
            end
            if (word_fired) word_valid = 1'b0;
            if (!len_valid && cmd_q.size() > 0 && (full || $urandom_range(0, 2) != 0)) begin
                len_valid = 1'b1;
                len       = LW'(cmd_q[0]);
            end
            if (!word_valid && (full || $urandom_range(0, 3) != 0)) begin
                word_valid = 1'b1;
                word_data  = rand_word();
            end
            pkt_if.rdy = full ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            o_valid = pkt_if.valid;
            o_sop   = pkt_if.sop;
            o_eop   = pkt_if.eop;
            o_empty = pkt_if.empty;
            o_data  = pkt_if.data;
            o_rdy   = pkt_if.rdy;

            check("zero_len_drop", DW'(zero_len_drop), DW'(drop_exp));
            check("len_rdy", DW'(len_rdy), DW'(rem == 0));
            check("word_rdy", DW'(word_rdy), DW'((rem != 0) && (!o_valid || o_rdy)));
            if (fired_prev) check("latency_valid", DW'(o_valid), DW'(1));
            if (hold_prev) begin
                check("hold_valid", DW'(o_valid), DW'(1));
                check("hold_data", o_data, prev.data);
                check("hold_flags", DW'({o_sop, o_eop, o_empty}), DW'({prev.sop, prev.eop, prev.empty}));
            end
            if (!o_valid) begin
                check("idle_data", o_data, '0);
                check("idle_flags", DW'({o_sop, o_eop, o_empty}), '0);
            end
            if (o_valid && o_rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", DW'(1), DW'(0));
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_data", o_data, exp_b.data);
                    check("beat_sop", DW'(o_sop), DW'(exp_b.sop));
                    check("beat_eop", DW'(o_eop), DW'(exp_b.eop));
                    check("beat_empty", DW'(o_empty), DW'(exp_b.empty));
                end
            end

            len_fired  = len_valid && len_rdy;
            word_fired = word_valid && word_rdy;
            drop_exp   = len_fired && (len == '0);
            fired_prev = word_fired;
            hold_prev  = o_valid && !o_rdy;
            prev       = '{data: o_data, sop: o_sop, eop: o_eop, empty: o_empty};
            if (len_fired && len != '0) begin
                l_cur = int'(len);
                n_cur = (l_cur + B - 1) / B;
                rem   = n_cur;
                k     = 0;
            end
            if (word_fired && rem > 0) begin
                exp_b.data  = word_data;
                exp_b.sop   = (k == 0);
                exp_b.eop   = (rem == 1);
                exp_b.empty = (rem == 1) ? EW'(n_cur * B - l_cur) : '0;
                exp_q.push_back(exp_b);
                k++;
                rem--;
            end
            cyc++;
        end while ((cmd_q.size() > 0 || rem > 0 || exp_q.size() > 0 || drop_exp) && cyc < budget);
        check("drain_timeout", DW'(cmd_q.size() + rem + exp_q.size()), '0);
        cmd_q.delete();
        len_valid  = 1'b0;
        word_valid = 1'b0;
    endtask

    initial begin
        len_valid  = 1'b0;
        len        = '0;
        word_valid = 1'b0;
        word_data  = '0;
        pkt_if.rdy = 1'b0;
        #1 rst = 1'b0;
        #12;
        check("rst_valid", DW'(pkt_if.valid), '0);
        check("rst_data", pkt_if.data, '0);
        check("rst_flags", DW'({pkt_if.sop, pkt_if.eop, pkt_if.empty}), '0);
        check("rst_drop", DW'(zero_len_drop), '0);
        check("rst_busy", DW'(busy), '0);
        @(negedge clk);
        rst = 1'b1;

        // Full-rate: multi-beat, exact-fit single beat, zero-length drop.
        cmd_q = '{40, 16, 0, 1, 17};
        run_traffic(1'b1, 2000);

        // Random valid/ready, including the maximum length.
        cmd_q = '{64, 0, 0, 65535, 32};
        for (int i = 0; i < 40; i++) begin
            cmd_q.push_back(($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 200)));
        end
        run_traffic(1'b0, 60000);

        // Reset after the first beat of a 48-byte packet.
        @(negedge clk);
        len_valid  = 1'b1;
        len        = LW'(48);
        pkt_if.rdy = 1'b1;
        @(negedge clk);
        len_valid  = 1'b0;
        word_valid = 1'b1;
        word_data  = rand_word();
        @(negedge clk);
        word_valid = 1'b0;
        #1;
        check("mid_beat0_valid", DW'(pkt_if.valid), DW'(1));
        check("mid_beat0_sop", DW'(pkt_if.sop), DW'(1));
        rst = 1'b0;
        #1;
        check("mid_rst_valid", DW'(pkt_if.valid), '0);
        check("mid_rst_busy", DW'(busy), '0);
        @(negedge clk);
        check("mid_rst_hold_valid", DW'(pkt_if.valid), '0);
        check("mid_rst_eop", DW'(pkt_if.eop), '0);
        rst = 1'b1;
        cmd_q = '{20};
        run_traffic(1'b1, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
